// File: rtl/dfr_axil_master.sv
// Single-outstanding AXI4-Lite master: turns cmd/rsp handshakes into AXI transactions.
// Latency 3 cycles from acceptance to rsp_valid with a zero-wait slave; cmd_ready low while busy, rsp held until rsp_ready.
module dfr_axil_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 9,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_wr,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [31:0]                     cmd_wdata,
  input  logic [3:0]                      cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [31:0]                     rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic                            busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RESP} state_t;

  state_t        state;
  logic [CW-1:0] tcnt;
  logic          aw_done, w_done;
  logic          aw_hs, w_hs, done, expired, in_txn;

  // done marks the event that advances the current state; it beats a same-cycle timeout
  always_comb begin
    aw_hs   = M_AXI_AWVALID & M_AXI_AWREADY;
    w_hs    = M_AXI_WVALID & M_AXI_WREADY;
    expired = (tcnt >= TERM);
    in_txn  = 1'b0;
    done    = 1'b0;
    case (state)
      WRITE: begin in_txn = 1'b1; done = (aw_done | aw_hs) & (w_done | w_hs); end
      WRESP: begin in_txn = 1'b1; done = M_AXI_BVALID; end
      READ:  begin in_txn = 1'b1; done = M_AXI_ARREADY; end
      RDATA: begin in_txn = 1'b1; done = M_AXI_RVALID; end
      default: begin in_txn = 1'b0; done = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tcnt          <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      cmd_ready     <= 1'b1;
      busy          <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
      rsp_timeout   <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      if (in_txn) tcnt <= tcnt + 1'b1;
      case (state)
        IDLE: if (cmd_valid) begin
          tcnt        <= '0;
          aw_done     <= 1'b0;
          w_done      <= 1'b0;
          cmd_ready   <= 1'b0;
          busy        <= 1'b1;
          rsp_timeout <= 1'b0;
          if (cmd_wr) begin
            M_AXI_AWADDR  <= cmd_addr;
            M_AXI_WDATA   <= cmd_wdata;
            M_AXI_WSTRB   <= cmd_wstrb;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            state         <= WRITE;
          end else begin
            M_AXI_ARADDR  <= cmd_addr;
            M_AXI_ARVALID <= 1'b1;
            state         <= READ;
          end
        end
        WRITE: begin
          if (aw_hs) begin M_AXI_AWVALID <= 1'b0; aw_done <= 1'b1; end
          if (w_hs)  begin M_AXI_WVALID  <= 1'b0; w_done  <= 1'b1; end
          if (done) begin
            M_AXI_BREADY <= 1'b1;
            state        <= WRESP;
          end
        end
        WRESP: if (done) begin
          M_AXI_BREADY <= 1'b0;
          rsp_resp     <= M_AXI_BRESP;
          rsp_rdata    <= '0;
          rsp_valid    <= 1'b1;
          state        <= RESP;
        end
        READ: if (done) begin
          M_AXI_ARVALID <= 1'b0;
          M_AXI_RREADY  <= 1'b1;
          state         <= RDATA;
        end
        RDATA: if (done) begin
          M_AXI_RREADY <= 1'b0;
          rsp_rdata    <= M_AXI_RDATA;
          rsp_resp     <= M_AXI_RRESP;
          rsp_valid    <= 1'b1;
          state        <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Abandon: overrides any handshake bookkeeping above for this cycle
      if (in_txn && expired && !done) begin
        M_AXI_AWVALID <= 1'b0;
        M_AXI_WVALID  <= 1'b0;
        M_AXI_BREADY  <= 1'b0;
        M_AXI_ARVALID <= 1'b0;
        M_AXI_RREADY  <= 1'b0;
        rsp_valid     <= 1'b1;
        rsp_timeout   <= 1'b1;
        rsp_resp      <= 2'b10;
        rsp_rdata     <= '0;
        state         <= RESP;
      end
    end
  end

endmodule

// File: tb/tb_dfr_axil_master.sv
// Directed bench for dfr_axil_master: vector table for zero-wait transactions plus corner-case sequences.
module tb_dfr_axil_master;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cmd_valid, cmd_ready, cmd_wr;
  logic [8:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [8:0]  M_AXI_AWADDR, M_AXI_ARADDR;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  dfr_axil_master #(
    .C_M_AXI_ADDR_WIDTH(9), .C_M_AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  typedef struct {
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[5];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   b_cnt = 0;

  // One B handshake per cycle where both are high (inputs are stable mid-cycle)
  always @(negedge clk) if (M_AXI_BVALID && M_AXI_BREADY) b_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic slave_idle();
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = 32'h0; M_AXI_RRESP = 2'b00;
  endtask

  // Present a command and step through its acceptance edge
  task automatic issue(input logic wr, input logic [8:0] addr, input logic [31:0] wd, input logic [3:0] ws);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic consume(input string name);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({name, "_rsp_drop"}, 32'(rsp_valid), 0);
    chk({name, "_cmd_ready"}, 32'(cmd_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, n, b0;
    logic seen;

    vecs[0] = '{1'b1, 9'h004, 32'hA5A5_0001, 4'hF, 32'h55AA_55AA, 2'b00, 32'h0,         2'b00};
    vecs[1] = '{1'b1, 9'h1FC, 32'h1234_5678, 4'h3, 32'h55AA_55AA, 2'b10, 32'h0,         2'b10};
    vecs[2] = '{1'b0, 9'h010, 32'h0,         4'h0, 32'hCAFE_F00D, 2'b00, 32'hCAFE_F00D, 2'b00};
    vecs[3] = '{1'b0, 9'h1FF, 32'h0,         4'h0, 32'h0000_0001, 2'b11, 32'h0000_0001, 2'b11};
    vecs[4] = '{1'b1, 9'h000, 32'hFFFF_FFFF, 4'h0, 32'h1111_2222, 2'b01, 32'h0,         2'b01};

    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    slave_idle();
    step(); step();
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                          M_AXI_RREADY, rsp_valid, rsp_timeout}), 0);
    chk("rst_payload", 32'(M_AXI_AWADDR) | 32'(M_AXI_ARADDR) | M_AXI_WDATA | 32'(M_AXI_WSTRB)
                       | rsp_rdata | 32'(rsp_resp), 0);
    rst = 1'b0;
    step();

    // Zero-wait slave: every transaction completes 3 cycles after acceptance
    for (int i = 0; i < 5; i++) begin
      M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_BVALID = 1'b1; M_AXI_BRESP = vecs[i].s_resp;
      M_AXI_ARREADY = 1'b1; M_AXI_RVALID = 1'b1; M_AXI_RDATA = vecs[i].s_rdata; M_AXI_RRESP = vecs[i].s_resp;
      chk($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 1);
      issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
      chk($sformatf("v%0d_busy", i), 32'(busy), 1);
      if (vecs[i].wr) begin
        chk($sformatf("v%0d_awvalid", i), 32'({M_AXI_AWVALID, M_AXI_WVALID}), 3);
        chk($sformatf("v%0d_awaddr", i), 32'(M_AXI_AWADDR), 32'(vecs[i].addr));
        chk($sformatf("v%0d_wdata", i), M_AXI_WDATA, vecs[i].wdata);
        chk($sformatf("v%0d_wstrb", i), 32'(M_AXI_WSTRB), 32'(vecs[i].wstrb));
      end else begin
        chk($sformatf("v%0d_arvalid", i), 32'(M_AXI_ARVALID), 1);
        chk($sformatf("v%0d_araddr", i), 32'(M_AXI_ARADDR), 32'(vecs[i].addr));
      end
      wait_rsp(lat);
      chk($sformatf("v%0d_latency", i), lat, 3);
      chk($sformatf("v%0d_resp", i), 32'(rsp_resp), 32'(vecs[i].exp_resp));
      chk($sformatf("v%0d_rdata", i), rsp_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_timeout", i), 32'(rsp_timeout), 0);
      slave_idle();
      consume($sformatf("v%0d", i));
    end

    // W accepted at once, AW stalls until its 5th cycle
    b0 = b_cnt;
    M_AXI_WREADY = 1'b1;
    issue(1'b1, 9'h020, 32'h0BAD_CAFE, 4'hC);
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("wfirst_awvalid_c%0d", c), 32'(M_AXI_AWVALID), 1);
      chk($sformatf("wfirst_awaddr_c%0d", c), 32'(M_AXI_AWADDR), 32'h020);
      chk($sformatf("wfirst_wvalid_c%0d", c), 32'(M_AXI_WVALID), (c == 1) ? 1 : 0);
      if (c == 5) M_AXI_AWREADY = 1'b1;
      step();
    end
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
    chk("wfirst_aw_drop", 32'(M_AXI_AWVALID), 0);
    chk("wfirst_bready", 32'(M_AXI_BREADY), 1);
    M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b00;
    step();
    M_AXI_BVALID = 1'b0;
    chk("wfirst_rsp_valid", 32'(rsp_valid), 1);
    chk("wfirst_bready_drop", 32'(M_AXI_BREADY), 0);
    step();
    chk("wfirst_one_b", b_cnt - b0, 1);
    consume("wfirst");

    // Read with AR and R wait states
    issue(1'b0, 9'h010, 32'h0, 4'h0);
    chk("rwait_arvalid_c1", 32'(M_AXI_ARVALID), 1);
    step();
    chk("rwait_arvalid_c2", 32'(M_AXI_ARVALID), 1);
    M_AXI_ARREADY = 1'b1;
    step();
    M_AXI_ARREADY = 1'b0;
    chk("rwait_ar_drop", 32'(M_AXI_ARVALID), 0);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("rwait_rready_c%0d", c), 32'(M_AXI_RREADY), 1);
      if (c == 3) begin
        M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'hDEAD_BEEF; M_AXI_RRESP = 2'b00;
      end
      step();
    end
    slave_idle();
    chk("rwait_rsp_valid", 32'(rsp_valid), 1);
    chk("rwait_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("rwait_resp", 32'(rsp_resp), 0);
    chk("rwait_rready_drop", 32'(M_AXI_RREADY), 0);
    consume("rwait");

    // Timeout: AR never accepted, ARVALID lasts exactly 16 cycles
    issue(1'b0, 9'h044, 32'h0, 4'h0);
    n = 0;
    while (M_AXI_ARVALID && n < 40) begin
      n++;
      step();
    end
    chk("tmo_arvalid_cycles", n, 16);
    chk("tmo_rsp_valid", 32'(rsp_valid), 1);
    chk("tmo_flag", 32'(rsp_timeout), 1);
    chk("tmo_resp", 32'(rsp_resp), 32'h2);
    chk("tmo_rdata", rsp_rdata, 0);
    consume("tmo");

    // AR accepted in the terminal-count cycle: handshake wins over the timeout
    issue(1'b0, 9'h048, 32'h0, 4'h0);
    for (int c = 1; c < 16; c++) step();
    chk("term_arvalid_c16", 32'(M_AXI_ARVALID), 1);
    M_AXI_ARREADY = 1'b1;
    step();
    M_AXI_ARREADY = 1'b0;
    chk("term_rready", 32'(M_AXI_RREADY), 1);
    chk("term_no_rsp_yet", 32'(rsp_valid), 0);
    M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'h0BAD_F00D;
    step();
    slave_idle();
    chk("term_rsp_valid", 32'(rsp_valid), 1);
    chk("term_timeout", 32'(rsp_timeout), 0);
    chk("term_rdata", rsp_rdata, 32'h0BAD_F00D);
    consume("term");

    // Response backpressure with a new command held pending
    M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b01;
    M_AXI_ARREADY = 1'b1; M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'h600D_CAFE; M_AXI_RRESP = 2'b00;
    issue(1'b1, 9'h080, 32'h0000_00FF, 4'h1);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 9'h0AA;
    wait_rsp(lat);
    chk("bp_latency", lat, 3);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("bp_hold_c%0d", c), 32'({rsp_valid, rsp_timeout, rsp_resp}), 32'b1001);
      chk($sformatf("bp_rdata_c%0d", c), rsp_rdata, 0);
      chk($sformatf("bp_cmd_ready_c%0d", c), 32'(cmd_ready), 0);
      step();
    end
    rsp_ready = 1'b1;
    chk("bp_cmd_ready_release_cycle", 32'(cmd_ready), 0);
    step();
    rsp_ready = 1'b0;
    chk("bp_rsp_drop", 32'(rsp_valid), 0);
    chk("bp_cmd_ready_after", 32'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0;
    chk("bp_next_arvalid", 32'(M_AXI_ARVALID), 1);
    chk("bp_next_araddr", 32'(M_AXI_ARADDR), 32'h0AA);
    wait_rsp(lat);
    chk("bp_next_latency", lat, 3);
    chk("bp_next_rdata", rsp_rdata, 32'h600D_CAFE);
    slave_idle();
    consume("bp_next");

    // Reset in the middle of a stalled write
    issue(1'b1, 9'h0C0, 32'h1357_9BDF, 4'hF);
    step();
    chk("rstmid_awvalid", 32'(M_AXI_AWVALID), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_flags", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                             M_AXI_RREADY, rsp_valid}), 0);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_cmd_ready", 32'(cmd_ready), 1);
    chk("rstmid_awaddr", 32'(M_AXI_AWADDR), 0);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (rsp_valid) seen = 1'b1;
    end
    chk("rstmid_no_rsp", 32'(seen), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
